e203_lsu_icb_splt: RTL and testbench

E203_LSU_ICB_SPLT -- requirements
Module: e203_lsu_icb_splt

---
 rtl/e203_lsu_icb_splt.sv | 175 +++++++++++++++++
 tb/tb_e203_lsu_icb_splt.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_lsu_icb_splt.sv
// LSU ICB splitter: routes upstream commands to DTCM, ITCM or BIU by address region
// and returns responses in order from the single target currently being served.
module e203_lsu_icb_splt #(
  parameter int OUTS_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dtcm_region_indic,
  input  logic [31:0] itcm_region_indic,

  input  logic        i_icb_cmd_valid,
  output logic        i_icb_cmd_ready,
  input  logic [31:0] i_icb_cmd_addr,
  input  logic        i_icb_cmd_read,
  input  logic [31:0] i_icb_cmd_wdata,
  input  logic [3:0]  i_icb_cmd_wmask,
  input  logic [1:0]  i_icb_cmd_size,
  output logic        i_icb_rsp_valid,
  input  logic        i_icb_rsp_ready,
  output logic        i_icb_rsp_err,
  output logic [31:0] i_icb_rsp_rdata,

  output logic        dtcm_icb_cmd_valid,
  input  logic        dtcm_icb_cmd_ready,
  output logic [31:0] dtcm_icb_cmd_addr,
  output logic        dtcm_icb_cmd_read,
  output logic [31:0] dtcm_icb_cmd_wdata,
  output logic [3:0]  dtcm_icb_cmd_wmask,
  output logic [1:0]  dtcm_icb_cmd_size,
  input  logic        dtcm_icb_rsp_valid,
  output logic        dtcm_icb_rsp_ready,
  input  logic        dtcm_icb_rsp_err,
  input  logic [31:0] dtcm_icb_rsp_rdata,

  output logic        itcm_icb_cmd_valid,
  input  logic        itcm_icb_cmd_ready,
  output logic [31:0] itcm_icb_cmd_addr,
  output logic        itcm_icb_cmd_read,
  output logic [31:0] itcm_icb_cmd_wdata,
  output logic [3:0]  itcm_icb_cmd_wmask,
  output logic [1:0]  itcm_icb_cmd_size,
  input  logic        itcm_icb_rsp_valid,
  output logic        itcm_icb_rsp_ready,
  input  logic        itcm_icb_rsp_err,
  input  logic [31:0] itcm_icb_rsp_rdata,

  output logic        biu_icb_cmd_valid,
  input  logic        biu_icb_cmd_ready,
  output logic [31:0] biu_icb_cmd_addr,
  output logic        biu_icb_cmd_read,
  output logic [31:0] biu_icb_cmd_wdata,
  output logic [3:0]  biu_icb_cmd_wmask,
  output logic [1:0]  biu_icb_cmd_size,
  input  logic        biu_icb_rsp_valid,
  output logic        biu_icb_rsp_ready,
  input  logic        biu_icb_rsp_err,
  input  logic [31:0] biu_icb_rsp_rdata,

  output logic [1:0]  outs_cnt
);

  localparam logic [1:0] TGT_DTCM = 2'b00;
  localparam logic [1:0] TGT_ITCM = 2'b01;
  localparam logic [1:0] TGT_BIU  = 2'b10;
  localparam logic [1:0] DEPTH    = 2'(OUTS_DEPTH);

  logic [1:0] r_outs_cnt;
  logic [1:0] r_cur_tgt;

  logic [1:0] w_tgt;
  logic       w_allowed;
  logic       w_tgt_ready;
  logic       w_cmd_hs;
  logic       w_rsp_hs;
  logic       w_active;

  // DTCM is checked first so it wins when both regions alias
  always_comb begin
    w_tgt = TGT_BIU;
    if (i_icb_cmd_addr[31:16] == dtcm_region_indic[31:16]) begin
      w_tgt = TGT_DTCM;
    end else if (i_icb_cmd_addr[31:16] == itcm_region_indic[31:16]) begin
      w_tgt = TGT_ITCM;
    end
  end

  // Allowance uses the registered count, so a target switch always waits one cycle after draining
  assign w_allowed = (r_outs_cnt < DEPTH) &&
                     ((r_outs_cnt == 2'd0) || (w_tgt == r_cur_tgt));

  always_comb begin
    case (w_tgt)
      TGT_DTCM: w_tgt_ready = dtcm_icb_cmd_ready;
      TGT_ITCM: w_tgt_ready = itcm_icb_cmd_ready;
      default:  w_tgt_ready = biu_icb_cmd_ready;
    endcase
  end

  assign i_icb_cmd_ready    = w_allowed & w_tgt_ready;
  assign dtcm_icb_cmd_valid = i_icb_cmd_valid & w_allowed & (w_tgt == TGT_DTCM);
  assign itcm_icb_cmd_valid = i_icb_cmd_valid & w_allowed & (w_tgt == TGT_ITCM);
  assign biu_icb_cmd_valid  = i_icb_cmd_valid & w_allowed & (w_tgt == TGT_BIU);

  assign dtcm_icb_cmd_addr  = i_icb_cmd_addr;
  assign dtcm_icb_cmd_read  = i_icb_cmd_read;
  assign dtcm_icb_cmd_wdata = i_icb_cmd_wdata;
  assign dtcm_icb_cmd_wmask = i_icb_cmd_wmask;
  assign dtcm_icb_cmd_size  = i_icb_cmd_size;
  assign itcm_icb_cmd_addr  = i_icb_cmd_addr;
  assign itcm_icb_cmd_read  = i_icb_cmd_read;
  assign itcm_icb_cmd_wdata = i_icb_cmd_wdata;
  assign itcm_icb_cmd_wmask = i_icb_cmd_wmask;
  assign itcm_icb_cmd_size  = i_icb_cmd_size;
  assign biu_icb_cmd_addr   = i_icb_cmd_addr;
  assign biu_icb_cmd_read   = i_icb_cmd_read;
  assign biu_icb_cmd_wdata  = i_icb_cmd_wdata;
  assign biu_icb_cmd_wmask  = i_icb_cmd_wmask;
  assign biu_icb_cmd_size   = i_icb_cmd_size;

  assign w_active = (r_outs_cnt != 2'd0);

  // With nothing outstanding, responses are neither forwarded nor acknowledged
  always_comb begin
    i_icb_rsp_valid    = 1'b0;
    i_icb_rsp_err      = 1'b0;
    i_icb_rsp_rdata    = 32'd0;
    dtcm_icb_rsp_ready = 1'b0;
    itcm_icb_rsp_ready = 1'b0;
    biu_icb_rsp_ready  = 1'b0;
    if (w_active) begin
      case (r_cur_tgt)
        TGT_DTCM: begin
          i_icb_rsp_valid    = dtcm_icb_rsp_valid;
          i_icb_rsp_err      = dtcm_icb_rsp_err;
          i_icb_rsp_rdata    = dtcm_icb_rsp_rdata;
          dtcm_icb_rsp_ready = i_icb_rsp_ready;
        end
        TGT_ITCM: begin
          i_icb_rsp_valid    = itcm_icb_rsp_valid;
          i_icb_rsp_err      = itcm_icb_rsp_err;
          i_icb_rsp_rdata    = itcm_icb_rsp_rdata;
          itcm_icb_rsp_ready = i_icb_rsp_ready;
        end
        default: begin
          i_icb_rsp_valid    = biu_icb_rsp_valid;
          i_icb_rsp_err      = biu_icb_rsp_err;
          i_icb_rsp_rdata    = biu_icb_rsp_rdata;
          biu_icb_rsp_ready  = i_icb_rsp_ready;
        end
      endcase
    end
  end

  assign w_cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready;
  assign w_rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outs_cnt <= 2'd0;
      r_cur_tgt  <= TGT_BIU;
    end else begin
      if (w_cmd_hs) begin
        r_cur_tgt <= w_tgt;
      end
      case ({w_cmd_hs, w_rsp_hs})
        2'b10:   r_outs_cnt <= r_outs_cnt + 2'd1;
        2'b01:   r_outs_cnt <= r_outs_cnt - 2'd1;
        default: r_outs_cnt <= r_outs_cnt;
      endcase
    end
  end

  assign outs_cnt = r_outs_cnt;

endmodule

// File: tb/tb_e203_lsu_icb_splt.sv
// Bench for e203_lsu_icb_splt: directed corner cases, then random traffic against
// a queue-based model of in-order routing with scoreboarded responses.
module tb_e203_lsu_icb_splt;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] dtcm_ind, itcm_ind;
  logic        u_cmd_valid;
  wire         u_cmd_ready;
  logic [31:0] u_addr, u_wdata;
  logic        u_read;
  logic [3:0]  u_wmask;
  logic [1:0]  u_size;
  wire         u_rsp_valid;
  logic        u_rsp_ready;
  wire         u_rsp_err;
  wire  [31:0] u_rsp_rdata;

  wire  [2:0]       t_cmd_valid;
  logic [2:0]       t_cmd_ready;
  wire  [2:0][31:0] t_cmd_addr;
  wire  [2:0]       t_cmd_read;
  wire  [2:0][31:0] t_cmd_wdata;
  wire  [2:0][3:0]  t_cmd_wmask;
  wire  [2:0][1:0]  t_cmd_size;
  logic [2:0]       t_rsp_valid;
  wire  [2:0]       t_rsp_ready;
  logic [2:0]       t_rsp_err;
  logic [2:0][31:0] t_rsp_rdata;
  wire  [1:0]       outs_cnt;

  e203_lsu_icb_splt #(.OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .dtcm_region_indic(dtcm_ind), .itcm_region_indic(itcm_ind),
    .i_icb_cmd_valid(u_cmd_valid), .i_icb_cmd_ready(u_cmd_ready),
    .i_icb_cmd_addr(u_addr), .i_icb_cmd_read(u_read), .i_icb_cmd_wdata(u_wdata),
    .i_icb_cmd_wmask(u_wmask), .i_icb_cmd_size(u_size),
    .i_icb_rsp_valid(u_rsp_valid), .i_icb_rsp_ready(u_rsp_ready),
    .i_icb_rsp_err(u_rsp_err), .i_icb_rsp_rdata(u_rsp_rdata),
    .dtcm_icb_cmd_valid(t_cmd_valid[0]), .dtcm_icb_cmd_ready(t_cmd_ready[0]),
    .dtcm_icb_cmd_addr(t_cmd_addr[0]), .dtcm_icb_cmd_read(t_cmd_read[0]),
    .dtcm_icb_cmd_wdata(t_cmd_wdata[0]), .dtcm_icb_cmd_wmask(t_cmd_wmask[0]),
    .dtcm_icb_cmd_size(t_cmd_size[0]),
    .dtcm_icb_rsp_valid(t_rsp_valid[0]), .dtcm_icb_rsp_ready(t_rsp_ready[0]),
    .dtcm_icb_rsp_err(t_rsp_err[0]), .dtcm_icb_rsp_rdata(t_rsp_rdata[0]),
    .itcm_icb_cmd_valid(t_cmd_valid[1]), .itcm_icb_cmd_ready(t_cmd_ready[1]),
    .itcm_icb_cmd_addr(t_cmd_addr[1]), .itcm_icb_cmd_read(t_cmd_read[1]),
    .itcm_icb_cmd_wdata(t_cmd_wdata[1]), .itcm_icb_cmd_wmask(t_cmd_wmask[1]),
    .itcm_icb_cmd_size(t_cmd_size[1]),
    .itcm_icb_rsp_valid(t_rsp_valid[1]), .itcm_icb_rsp_ready(t_rsp_ready[1]),
    .itcm_icb_rsp_err(t_rsp_err[1]), .itcm_icb_rsp_rdata(t_rsp_rdata[1]),
    .biu_icb_cmd_valid(t_cmd_valid[2]), .biu_icb_cmd_ready(t_cmd_ready[2]),
    .biu_icb_cmd_addr(t_cmd_addr[2]), .biu_icb_cmd_read(t_cmd_read[2]),
    .biu_icb_cmd_wdata(t_cmd_wdata[2]), .biu_icb_cmd_wmask(t_cmd_wmask[2]),
    .biu_icb_cmd_size(t_cmd_size[2]),
    .biu_icb_rsp_valid(t_rsp_valid[2]), .biu_icb_rsp_ready(t_rsp_ready[2]),
    .biu_icb_rsp_err(t_rsp_err[2]), .biu_icb_rsp_rdata(t_rsp_rdata[2]),
    .outs_cnt(outs_cnt)
  );

  typedef struct packed { logic [31:0] d; logic e; } exp_t;
  typedef struct packed { logic [1:0] p; logic [31:0] a; } pend_t;

  exp_t  exp_q[$];
  pend_t pq[$];
  int    total = 0;
  int    bad = 0;
  bit    auto_tgt = 1'b0;
  logic [1:0] last_tgt = 2'd2;
  int    region = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dec(input logic [31:0] a);
    if (a[31:16] == dtcm_ind[31:16]) return 2'd0;
    if (a[31:16] == itcm_ind[31:16]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] rdat(input logic [1:0] p, input logic [31:0] a);
    return a ^ (({30'd0, p} + 32'd1) * 32'h1357_9BDF);
  endfunction

  function automatic logic rerr(input logic [31:0] a);
    return a[2] ^ a[7];
  endfunction

  function automatic bit has_pending(input logic [1:0] p);
    foreach (pq[i]) if (pq[i].p == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [31:0] d, input logic e);
    exp_q.push_back({d, e});
  endtask

  task automatic idle();
    u_cmd_valid = 1'b0; u_addr = 32'd0; u_read = 1'b1; u_wdata = 32'd0;
    u_wmask = 4'hF; u_size = 2'd2; u_rsp_ready = 1'b1;
    t_cmd_ready = 3'b111; t_rsp_valid = 3'b000; t_rsp_err = 3'b000; t_rsp_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on upstream response handshakes; target models track accepted commands
  exp_t m_e;
  always @(negedge clk) begin
    if (u_rsp_valid && u_rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got rdata %h, no response was outstanding", u_rsp_rdata);
      end else begin
        m_e = exp_q.pop_front();
        chk("rsp_rdata", u_rsp_rdata, m_e.d);
        chk("rsp_err", {31'd0, u_rsp_err}, {31'd0, m_e.e});
      end
    end
    if (auto_tgt) begin
      for (int p = 0; p < 3; p++) begin
        if (t_rsp_valid[p] && t_rsp_ready[p]) begin
          total++;
          if (pq.size() == 0 || pq[0].p != p[1:0]) begin
            bad++;
            $display("FAIL tgt_rsp_ack: port %0d acknowledged with no pending command", p);
          end else begin
            void'(pq.pop_front());
          end
        end
      end
      for (int p = 0; p < 3; p++)
        if (t_cmd_valid[p] && t_cmd_ready[p]) pq.push_back({p[1:0], t_cmd_addr[p]});
    end
  end

  task automatic drive_random(input bit issue);
    for (int p = 0; p < 3; p++) begin
      if (pq.size() > 0 && pq[0].p == p[1:0] && ($urandom % 2 == 1)) begin
        t_rsp_valid[p] = 1'b1;
        t_rsp_rdata[p] = rdat(p[1:0], pq[0].a);
        t_rsp_err[p]   = rerr(pq[0].a);
      end else if (!has_pending(p[1:0]) && ($urandom % 6 == 0)) begin
        t_rsp_valid[p] = 1'b1;
        t_rsp_rdata[p] = $urandom;
        t_rsp_err[p]   = 1'($urandom);
      end else begin
        t_rsp_valid[p] = 1'b0;
      end
    end
    t_cmd_ready = 3'($urandom);
    u_rsp_ready = ($urandom % 4) != 0;
    if (issue && ($urandom % 10 < 7)) begin
      if ($urandom % 5 == 0) region = $urandom % 3;
      u_cmd_valid = 1'b1;
      case (region)
        0:       u_addr = {16'h9000, 16'($urandom)};
        1:       u_addr = {16'h8000, 16'($urandom)};
        default: u_addr = {4'h1, 28'($urandom)};
      endcase
      u_read = 1'($urandom); u_wdata = $urandom;
      u_wmask = 4'($urandom); u_size = 2'($urandom);
    end else begin
      u_cmd_valid = 1'b0;
    end
  endtask

  task automatic check_cycle();
    logic [1:0] tgt;
    int         n;
    bit         allowed;
    logic [2:0] exp_cv;
    tgt = dec(u_addr);
    n = exp_q.size();
    chk("outs_cnt", {30'd0, outs_cnt}, n);
    allowed = (n < DEPTH) && (n == 0 || tgt == last_tgt);
    chk("cmd_ready", {31'd0, u_cmd_ready}, {31'd0, allowed && t_cmd_ready[tgt]});
    exp_cv = (u_cmd_valid && allowed) ? (3'b001 << tgt) : 3'b000;
    chk("cmd_valid_route", {29'd0, t_cmd_valid}, {29'd0, exp_cv});
    chk("cmd_addr", t_cmd_addr[tgt], u_addr);
    chk("cmd_wdata", t_cmd_wdata[tgt], u_wdata);
    chk("cmd_ctl", {25'd0, t_cmd_read[tgt], t_cmd_wmask[tgt], t_cmd_size[tgt]},
        {25'd0, u_read, u_wmask, u_size});
    chk("rsp_valid", {31'd0, u_rsp_valid}, {31'd0, (n > 0) && t_rsp_valid[last_tgt]});
    chk("rsp_ready_route", {29'd0, t_rsp_ready},
        (n > 0) ? ({31'd0, u_rsp_ready} << last_tgt) : 32'd0);
    if (u_cmd_valid && u_cmd_ready) begin
      push(rdat(tgt, u_addr), rerr(u_addr));
      last_tgt = tgt;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    dtcm_ind = 32'h9000_0000;
    itcm_ind = 32'h8000_0000;
    cyc(); cyc();
    t_rsp_valid = 3'b111; t_rsp_rdata = '1;
    #1;
    chk("reset_outs_cnt", {30'd0, outs_cnt}, 32'd0);
    chk("reset_rsp_valid", {31'd0, u_rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", u_rsp_rdata, 32'd0);
    chk("reset_tgt_rsp_ready", {29'd0, t_rsp_ready}, 32'd0);
    chk("reset_cmd_valid", {29'd0, t_cmd_valid}, 32'd0);
    idle();
    rst_n = 1'b1;
    cyc();

    // Region decode, no clock edge while probing
    u_cmd_valid = 1'b1; u_wdata = 32'hA5A5_0001;
    u_addr = 32'h9000_0010; #1;
    chk("route_dtcm", {29'd0, t_cmd_valid}, 32'h1);
    chk("ready_dtcm_idle", {31'd0, u_cmd_ready}, 32'h1);
    u_addr = 32'h8000_FFFC; #1;
    chk("route_itcm", {29'd0, t_cmd_valid}, 32'h2);
    u_addr = 32'h1000_0000; #1;
    chk("route_biu", {29'd0, t_cmd_valid}, 32'h4);
    chk("biu_addr", t_cmd_addr[2], 32'h1000_0000);
    chk("biu_wdata", t_cmd_wdata[2], 32'hA5A5_0001);
    itcm_ind = 32'h9000_0000; u_addr = 32'h9000_0000; #1;
    chk("route_alias_dtcm", {29'd0, t_cmd_valid}, 32'h1);
    u_cmd_valid = 1'b0; itcm_ind = 32'h8000_0000;
    cyc();

    // Fill to depth with DTCM reads, then return one
    u_cmd_valid = 1'b1; u_addr = 32'h9000_0010; u_read = 1'b1;
    push(32'hDEAD_BEEF, 1'b0); cyc();
    chk("fill_cnt1", {30'd0, outs_cnt}, 32'd1);
    push(32'h0000_1111, 1'b0); cyc();
    chk("fill_cnt2", {30'd0, outs_cnt}, 32'd2);
    chk("full_cmd_ready", {31'd0, u_cmd_ready}, 32'd0);
    chk("full_cmd_valid", {29'd0, t_cmd_valid}, 32'd0);
    u_cmd_valid = 1'b0;
    t_rsp_valid[0] = 1'b1; t_rsp_rdata[0] = 32'hDEAD_BEEF; t_rsp_err[0] = 1'b0; #1;
    chk("dtcm_rsp_rdata", u_rsp_rdata, 32'hDEAD_BEEF);
    chk("dtcm_rsp_valid", {31'd0, u_rsp_valid}, 32'd1);
    chk("dtcm_rsp_ready", {29'd0, t_rsp_ready}, 32'h1);
    cyc();
    chk("cnt_after_rsp", {30'd0, outs_cnt}, 32'd1);

    // Target switch must wait for drain plus one cycle
    t_rsp_valid[0] = 1'b0;
    u_cmd_valid = 1'b1; u_addr = 32'h1000_0000; u_read = 1'b0; #1;
    chk("switch_blocked_ready", {31'd0, u_cmd_ready}, 32'd0);
    chk("switch_blocked_valid", {29'd0, t_cmd_valid}, 32'd0);
    cyc();
    chk("switch_blocked_ready2", {31'd0, u_cmd_ready}, 32'd0);
    chk("switch_blocked_cnt", {30'd0, outs_cnt}, 32'd1);
    t_rsp_valid[0] = 1'b1; t_rsp_rdata[0] = 32'h0000_1111; #1;
    chk("switch_same_cycle_ready", {31'd0, u_cmd_ready}, 32'd0);
    chk("switch_same_cycle_valid", {29'd0, t_cmd_valid}, 32'd0);
    cyc();
    t_rsp_valid[0] = 1'b0; #1;
    chk("drained_cnt", {30'd0, outs_cnt}, 32'd0);
    chk("switch_ready", {31'd0, u_cmd_ready}, 32'd1);
    chk("switch_valid_biu", {29'd0, t_cmd_valid}, 32'h4);
    push(32'h0000_2222, 1'b0); cyc();
    u_cmd_valid = 1'b0;
    chk("biu_cnt", {30'd0, outs_cnt}, 32'd1);
    t_rsp_valid[2] = 1'b1; t_rsp_rdata[2] = 32'h0000_2222; cyc();
    t_rsp_valid[2] = 1'b0;
    chk("biu_drained", {30'd0, outs_cnt}, 32'd0);

    // Simultaneous ITCM command and response
    u_cmd_valid = 1'b1; u_addr = 32'h8000_0004; u_read = 1'b1;
    push(32'h0000_3333, 1'b1); cyc();
    chk("itcm_cnt1", {30'd0, outs_cnt}, 32'd1);
    u_addr = 32'h8000_0008; push(32'h0000_4444, 1'b0);
    t_rsp_valid[1] = 1'b1; t_rsp_rdata[1] = 32'h0000_3333; t_rsp_err[1] = 1'b1; #1;
    chk("itcm_rsp_err", {31'd0, u_rsp_err}, 32'd1);
    chk("itcm_both_ready", {31'd0, u_cmd_ready}, 32'd1);
    cyc();
    u_cmd_valid = 1'b0; t_rsp_rdata[1] = 32'h0000_4444; t_rsp_err[1] = 1'b0;
    chk("itcm_cnt_hold", {30'd0, outs_cnt}, 32'd1);
    cyc();
    t_rsp_valid[1] = 1'b0;
    chk("itcm_drained", {30'd0, outs_cnt}, 32'd0);

    // Stray responses while idle
    t_rsp_valid = 3'b111; t_rsp_rdata = '1; t_rsp_err = 3'b111; #1;
    chk("idle_rsp_valid", {31'd0, u_rsp_valid}, 32'd0);
    chk("idle_rsp_rdata", u_rsp_rdata, 32'd0);
    chk("idle_rsp_err", {31'd0, u_rsp_err}, 32'd0);
    chk("idle_tgt_rsp_ready", {29'd0, t_rsp_ready}, 32'd0);
    cyc();
    chk("idle_cnt", {30'd0, outs_cnt}, 32'd0);
    t_rsp_valid = 3'b000; t_rsp_err = 3'b000;

    // Reset with two outstanding; later responses are ignored
    u_cmd_valid = 1'b1; u_addr = 32'h9000_0020;
    cyc(); cyc();
    u_cmd_valid = 1'b0;
    chk("pre_reset_cnt", {30'd0, outs_cnt}, 32'd2);
    u_rsp_ready = 1'b0; rst_n = 1'b0;
    t_rsp_valid[0] = 1'b1; t_rsp_rdata[0] = 32'hBAD0_BAD0;
    cyc();
    rst_n = 1'b1;
    chk("midreset_cnt", {30'd0, outs_cnt}, 32'd0);
    chk("midreset_rsp_valid", {31'd0, u_rsp_valid}, 32'd0);
    u_rsp_ready = 1'b1; #1;
    chk("late_rsp_ready", {29'd0, t_rsp_ready}, 32'd0);
    cyc();
    chk("late_rsp_cnt", {30'd0, outs_cnt}, 32'd0);
    idle();
    exp_q.delete();
    last_tgt = 2'd2;

    // Random traffic against the queue model
    auto_tgt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      drive_random(1'b1);
      #1;
      check_cycle();
    end
    for (int i = 0; i < 400 && (exp_q.size() > 0 || pq.size() > 0); i++) begin
      @(posedge clk); #1;
      drive_random(1'b0);
      #1;
      check_cycle();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
